// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared types and default widths for the fetch front end.
// Consumed by pc_fetch_unit, its interface, its record buffer and the bench.
package pc_fetch_unit_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_ADDR_W-1:0]  pc_inc;
  } fetch_rec_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: imem req/ack bus plus the valid/ready record link to decode.
// master = fetch unit side, slave = memory/decode side.
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_pc_inc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_inc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_inc
  );

endinterface

// File: rtl/pc_fetch_unit_fetch_buf.sv
// fetch_buf: valid/ready record buffer, depth 1 or 2, head always in ent0.
// room_nxt reports whether a further push fits after this edge.
module fetch_buf
  import pc_fetch_unit_pkg::*;
#(
  parameter int W     = DEF_INSTR_W + 2 * DEF_ADDR_W,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         room_nxt
);

  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         push;
  logic         pop;

  assign out_valid = cnt != 2'd0;
  assign out_data  = ent0;
  assign pop       = out_valid && out_ready;
  assign in_ready  = (cnt < 2'(DEPTH)) || pop;
  assign push      = in_valid && in_ready;
  assign cnt_nxt   = cnt + 2'(push) - 2'(pop);
  assign room_nxt  = cnt_nxt < 2'(DEPTH);

  // occupancy and entry shifting; flush empties without touching data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_nxt;
      if (pop) begin
        if (cnt == 2'd2) begin
          ent0 <= ent1;
          if (push) ent1 <= in_data;
        end else if (push) begin
          ent0 <= in_data;
        end
      end else if (push) begin
        if (cnt == 2'd0) ent0 <= in_data;
        else             ent1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner, imem fetch FSM, record hand-off to decode.
// FETCH_SKID_EN selects a 2-entry output buffer; default is one register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  pc_fetch_unit_if.master   bus
);

`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int REC_W = INSTR_W + 2 * ADDR_W;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_STALL = STALL;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              push;
  logic              in_ready;
  logic              out_valid;
  logic              pop;
  logic              room_nxt;
  logic              stay;
  logic [REC_W-1:0]  rec_in;
  logic [REC_W-1:0]  rec_out;

  assign pc_inc = pc + ADDR_W'(1);
  assign push   = (state == S_REQ) && bus.imem_ack && !redirect_valid;
  assign rec_in = {bus.imem_rdata, pc, pc_inc};
  assign pop    = out_valid && bus.if_ready;
  assign stay   = room_nxt || bus.if_ready;

  fetch_buf #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .in_valid  (push),
    .in_data   (rec_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (rec_out),
    .out_ready (bus.if_ready),
    .room_nxt  (room_nxt)
  );

  // next state / next pc; redirect overrides every other transition.
  // An ack that finds no buffer room is discarded and refetched later.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      unique case (state)
        S_REQ, S_DRAIN: state_nxt = bus.imem_ack ? S_REQ : S_DRAIN;
        default:        state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (bus.imem_ack) begin
            if (in_ready) begin
              pc_nxt    = pc_inc;
              state_nxt = stay ? S_REQ : S_STALL;
            end else begin
              state_nxt = S_STALL;
            end
          end
        end
        S_STALL: if (pop || !out_valid) state_nxt = S_REQ;
        S_DRAIN: if (bus.imem_ack) state_nxt = S_REQ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state, pc and the held request address (frozen while draining)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state_nxt != S_DRAIN) addr_q <= pc_nxt;
    end
  end

  assign bus.imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = out_valid;
  assign {bus.if_instr, bus.if_pc, bus.if_pc_inc} = rec_out;

endmodule
